// File: rtl/ternary_pkg.sv
// rtl/ternary_pkg.sv - balanced-ternary trit encoding, op codes, FSM states and trit helpers
package ternary_pkg;

    localparam logic [1:0] TRIT_Z = 2'b00;
    localparam logic [1:0] TRIT_P = 2'b01;
    localparam logic [1:0] TRIT_N = 2'b10;
    localparam logic [1:0] TRIT_X = 2'b11;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_MIN = 3'd3;
    localparam logic [2:0] OP_MAX = 3'd4;
    localparam logic [2:0] OP_NEG = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The invalid code 2'b11 decodes as zero; flagging it is the caller's job.
    function automatic logic signed [2:0] trit_decode(input logic [1:0] t);
        case (t)
            TRIT_P:  trit_decode = 3'sd1;
            TRIT_N:  trit_decode = -3'sd1;
            default: trit_decode = 3'sd0;
        endcase
    endfunction

    function automatic logic [1:0] trit_encode(input logic signed [2:0] v);
        if (v > 3'sd0)
            trit_encode = TRIT_P;
        else if (v < 3'sd0)
            trit_encode = TRIT_N;
        else
            trit_encode = TRIT_Z;
    endfunction

    function automatic logic [1:0] trit_negate(input logic [1:0] t);
        case (t)
            TRIT_P:  trit_negate = TRIT_N;
            TRIT_N:  trit_negate = TRIT_P;
            default: trit_negate = TRIT_Z;
        endcase
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        op_legal = (op <= OP_NEG);
    endfunction

endpackage

// File: rtl/ternary_trit_slice.sv
// rtl/ternary_trit_slice.sv - one balanced-ternary digit of the ALU datapath, reused serially
module ternary_trit_slice
    import ternary_pkg::*;
(
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic [1:0] carry_i,
    input  logic [2:0] op,
    output logic [1:0] digit,
    output logic [1:0] carry_o
);

    logic signed [2:0] av;
    logic signed [2:0] bv;
    logic signed [2:0] cv;
    logic signed [3:0] sum;

    always_comb begin
        av  = trit_decode(a_i);
        bv  = trit_decode((op == OP_SUB) ? trit_negate(b_i) : b_i);
        cv  = trit_decode(carry_i);
        sum = 4'(av) + 4'(bv) + 4'(cv);

        digit   = TRIT_Z;
        carry_o = TRIT_Z;
        case (op)
            OP_ADD, OP_SUB: begin
                // Sum lies in -3..+3; fold the out-of-range part into the carry trit.
                if (sum >= 4'sd2) begin
                    digit   = trit_encode(3'(sum - 4'sd3));
                    carry_o = TRIT_P;
                end else if (sum <= -4'sd2) begin
                    digit   = trit_encode(3'(sum + 4'sd3));
                    carry_o = TRIT_N;
                end else begin
                    digit   = trit_encode(3'(sum));
                end
            end
            OP_MUL:  digit = trit_encode(av * bv);
            OP_MIN:  digit = trit_encode((av < bv) ? av : bv);
            OP_MAX:  digit = trit_encode((av > bv) ? av : bv);
            OP_NEG:  digit = trit_encode(-av);
            default: digit = TRIT_Z;
        endcase
    end

endmodule

// File: rtl/ternary_serial_alu.sv
// rtl/ternary_serial_alu.sv - trit-serial balanced-ternary ALU; TERNARY_ALU_SAT_EN enables ADD/SUB saturation
module ternary_serial_alu
    import ternary_pkg::*;
#(
    parameter int N_TRITS = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             op,
    input  logic [2*N_TRITS-1:0]   a,
    input  logic [2*N_TRITS-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N_TRITS-1:0]   result,
    output logic [1:0]             carry_out,
    output logic                   err
);

    localparam int W  = 2 * N_TRITS;
    localparam int IW = $clog2(N_TRITS);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      carry_q, carry_d;
    logic [W-1:0]    result_q, result_d;
    logic            err_q, err_d;

    logic [1:0]      a_cur;
    logic [1:0]      b_cur;
    logic [1:0]      digit;
    logic [1:0]      slice_carry;
    logic            any_invalid;
    logic            last_trit;

    assign a_cur     = a_q[{idx_q, 1'b0} +: 2];
    assign b_cur     = b_q[{idx_q, 1'b0} +: 2];
    assign last_trit = (idx_q == IW'(N_TRITS - 1));

    ternary_trit_slice u_slice (
        .a_i     (a_cur),
        .b_i     (b_cur),
        .carry_i (carry_q),
        .op      (op_q),
        .digit   (digit),
        .carry_o (slice_carry)
    );

    always_comb begin
        any_invalid = 1'b0;
        for (int i = 0; i < N_TRITS; i++) begin
            if (a[2*i +: 2] == TRIT_X || b[2*i +: 2] == TRIT_X)
                any_invalid = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    idx_d    = '0;
                    carry_d  = TRIT_Z;
                    result_d = '0;
                    err_d    = !op_legal(op) || any_invalid;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[{idx_q, 1'b0} +: 2] = digit;
                carry_d = slice_carry;
                idx_d   = idx_q + 1'b1;
                if (last_trit) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
`ifdef TERNARY_ALU_SAT_EN
                    // Overflow clamps the word to the extreme of the carry's sign.
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        if (slice_carry == TRIT_P)
                            result_d = {N_TRITS{TRIT_P}};
                        else if (slice_carry == TRIT_N)
                            result_d = {N_TRITS{TRIT_N}};
                    end
`endif
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            idx_q    <= '0;
            carry_q  <= TRIT_Z;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ternary_serial_alu.sv
// tb/tb_ternary_serial_alu.sv - directed table, handshake/reset sequences and random checks for ternary_serial_alu
module tb_ternary_serial_alu;

    localparam int N    = 9;
    localparam int W    = 2 * N;
    localparam int POW  = 19683;
    localparam int HALF = 9841;

    typedef logic [W-1:0] word_t;

    typedef struct {
        string      name;
        logic [2:0] op;
        word_t      a;
        word_t      b;
        word_t      er;
        logic [1:0] ec;
        logic       ee;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    word_t      a;
    word_t      b;
    logic       out_valid;
    logic       out_ready;
    word_t      result;
    logic [1:0] carry_out;
    logic       err;

    int total = 0;
    int bad   = 0;

    ternary_serial_alu #(.N_TRITS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic int dec(input logic [1:0] t);
        if (t == 2'b01) return 1;
        if (t == 2'b10) return -1;
        return 0;
    endfunction

    function automatic logic [1:0] enc(input int d);
        if (d > 0) return 2'b01;
        if (d < 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic word_t to_word(input int v);
        word_t w = '0;
        int    r;
        for (int i = 0; i < N; i++) begin
            r = ((v % 3) + 3) % 3;
            if (r == 2) begin
                w[2*i +: 2] = 2'b10;
                v = (v + 1) / 3;
            end else if (r == 1) begin
                w[2*i +: 2] = 2'b01;
                v = (v - 1) / 3;
            end else begin
                v = v / 3;
            end
        end
        return w;
    endfunction

    function automatic int from_word(input word_t w);
        int v = 0;
        for (int i = N - 1; i >= 0; i--)
            v = v * 3 + dec(w[2*i +: 2]);
        return v;
    endfunction

    function automatic logic has_x(input word_t w);
        for (int i = 0; i < N; i++)
            if (w[2*i +: 2] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    // Arithmetic reference: integers for ADD/SUB, per-digit integers for the tritwise ops.
    task automatic model(input logic [2:0] o, input word_t x, input word_t y,
                         output word_t r, output logic [1:0] c, output logic e);
        int s, cy, tx, ty, d;
        r = '0;
        c = 2'b00;
        e = (o > 3'd5) || has_x(x) || has_x(y);
        case (o)
            3'd0, 3'd1: begin
                s  = from_word(x) + ((o == 3'd0) ? from_word(y) : -from_word(y));
                cy = (s > HALF) ? 1 : ((s < -HALF) ? -1 : 0);
                r  = to_word(s - cy * POW);
                c  = enc(cy);
`ifdef TERNARY_ALU_SAT_EN
                if (cy != 0) r = to_word(cy * HALF);
`endif
            end
            3'd2, 3'd3, 3'd4, 3'd5: begin
                for (int i = 0; i < N; i++) begin
                    tx = dec(x[2*i +: 2]);
                    ty = dec(y[2*i +: 2]);
                    case (o)
                        3'd2:    d = tx * ty;
                        3'd3:    d = (tx < ty) ? tx : ty;
                        3'd4:    d = (tx > ty) ? tx : ty;
                        default: d = -tx;
                    endcase
                    r[2*i +: 2] = enc(d);
                end
            end
            default: r = '0;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input word_t x, input word_t y,
                          output word_t r, output logic [1:0] c, output logic e, output int lat);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        c = carry_out;
        e = err;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t       vt[9];
    word_t      r, er, mixed;
    logic [1:0] c, ec;
    logic       e, ee;
    int         lat;
    logic [2:0] ro;
    word_t      ra, rb;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 3'd0;
        a = '0;
        b = '0;

        mixed = to_word(-2) | (word_t'(2'b11) << 6);
        vt[0] = '{"add_1_1",   3'd0, to_word(1),     to_word(1),     to_word(2),  2'b00, 1'b0};
`ifdef TERNARY_ALU_SAT_EN
        vt[1] = '{"add_allp",  3'd0, to_word(HALF),  to_word(HALF),  to_word(HALF),  2'b01, 1'b0};
        vt[2] = '{"add_alln",  3'd0, to_word(-HALF), to_word(-HALF), to_word(-HALF), 2'b10, 1'b0};
`else
        vt[1] = '{"add_allp",  3'd0, to_word(HALF),  to_word(HALF),  to_word(-1), 2'b01, 1'b0};
        vt[2] = '{"add_alln",  3'd0, to_word(-HALF), to_word(-HALF), to_word(1),  2'b10, 1'b0};
`endif
        vt[3] = '{"sub_5_7",   3'd1, to_word(5),     to_word(7),     to_word(-2), 2'b00, 1'b0};
        vt[4] = '{"neg_m13",   3'd5, to_word(-13),   to_word(0),     to_word(13), 2'b00, 1'b0};
        vt[5] = '{"min_mixed", 3'd3, mixed,          to_word(HALF),  to_word(-2), 2'b00, 1'b1};
        vt[6] = '{"max_mixed", 3'd4, mixed,          to_word(HALF),  to_word(HALF), 2'b00, 1'b1};
        vt[7] = '{"mul_mixed", 3'd2, mixed,          to_word(HALF),  to_word(-2), 2'b00, 1'b1};
        vt[8] = '{"illegal",   3'd6, to_word(40),    to_word(-7),    to_word(0),  2'b00, 1'b1};

        #12;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    32'(result),        32'd0);
        check("rst_carry",     {30'd0, carry_out}, 32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, r, c, e, lat);
            check({vt[i].name, "_result"}, 32'(r), 32'(vt[i].er));
            check({vt[i].name, "_carry"}, {30'd0, c}, {30'd0, vt[i].ec});
            check({vt[i].name, "_err"}, {31'd0, e}, {31'd0, vt[i].ee});
            check({vt[i].name, "_latency"}, 32'(lat), 32'(N));
        end

        // Back-pressure in DONE with operand churn during RUN and ignored requests in DONE.
        @(negedge clk);
        op = 3'd0;
        a = to_word(20);
        b = to_word(-7);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            a = word_t'($urandom);
            b = word_t'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(N));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = 3'd4;
            a = word_t'($urandom);
            @(posedge clk);
            #1;
            check("bp_result_hold", 32'(result), 32'(to_word(13)));
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        check("bp_out_valid_after", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of RUN, then a normal request.
        @(negedge clk);
        op = 3'd0;
        a = to_word(100) | (word_t'(2'b11) << 16);
        b = to_word(250);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result",    32'(result),        32'd0);
        check("mid_rst_carry",     {30'd0, carry_out}, 32'd0);
        check("mid_rst_err",       {31'd0, err},       32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd0, to_word(3), to_word(4), r, c, e, lat);
        check("post_rst_result", 32'(r), 32'(to_word(7)));
        check("post_rst_err", {31'd0, e}, 32'd0);
        check("post_rst_latency", 32'(lat), 32'(N));

        for (int n = 0; n < 250; n++) begin
            ro = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            for (int i = 0; i < N; i++) begin
                ra[2*i +: 2] = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                rb[2*i +: 2] = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            end
            model(ro, ra, rb, er, ec, ee);
            run_op(ro, ra, rb, r, c, e, lat);
            check("rand_result", 32'(r), 32'(er));
            check("rand_carry", {30'd0, c}, {30'd0, ec});
            check("rand_err", {31'd0, e}, {31'd0, ee});
            check("rand_latency", 32'(lat), 32'(N));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
